// File: rtl/seg_scan_ctrl_if.sv
// Display-word load handshake for seg_scan_ctrl. The producer drives the word
// and load_valid; the scanner answers with load_ready.
interface seg_scan_ctrl_if;
  logic        load_valid;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic        load_ready;

  modport master (output load_valid, load_data, load_dp, input load_ready);
  modport slave  (input load_valid, load_data, load_dp, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-seg scanner. Each enabled digit is lit for a
// programmable dwell, then all anodes go dark briefly. New words are double-buffered.
module seg_scan_ctrl #(
  parameter int DIV_W     = 6,
  parameter int BLANK_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] period,
  input  logic [3:0]       digit_en,
  seg_scan_ctrl_if.slave   ld,
  output logic [3:0]       an,
  output logic [3:0]       hex,
  output logic             dp,
  output logic [1:0]       digit_sel,
  output logic             frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_BLANK} state_t;

  localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYC - 1);

  state_t           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [3:0]       bcnt_q;
  logic [3:0]       an_q, hex_q;
  logic             dp_q, fd_q;
  logic [1:0]       sel_q;
  logic [15:0]      act_word_q, pend_word_q;
  logic [3:0]       act_dp_q, pend_dp_q;
  logic             pend_full_q;

  logic [1:0]  low_idx, wrap_idx, cand, sel_d;
  logic        found, idle_go, blank_end, wrap, enter_show, boundary, xfer;
  logic [15:0] src_word;
  logic [3:0]  src_dp, hex_d;
  logic        dp_d;

  // Next-digit search: first enabled index above the current one, wrapping mod 4.
  always_comb begin
    low_idx  = '0;
    wrap_idx = '0;
    cand     = '0;
    found    = 1'b0;
    for (int k = 3; k >= 0; k--)
      if (digit_en[k]) low_idx = 2'(k);
    wrap_idx = low_idx;
    for (int k = 1; k < 5; k++) begin
      cand = sel_q + 2'(k);
      if (!found && digit_en[cand]) begin
        wrap_idx = cand;
        found    = 1'b1;
      end
    end

    idle_go    = (state_q == S_IDLE) && (|digit_en);
    blank_end  = (state_q == S_BLANK) && (bcnt_q == BLANK_LAST);
    wrap       = (wrap_idx <= sel_q);
    sel_d      = idle_go ? low_idx : wrap_idx;
    enter_show = idle_go || (blank_end && (|digit_en));
    boundary   = idle_go || (blank_end && (|digit_en) && wrap);
    xfer       = pend_full_q && ((state_q == S_IDLE) || boundary);

    // On a transfer edge the first digit of the frame must already see the new word.
    src_word = xfer ? pend_word_q : act_word_q;
    src_dp   = xfer ? pend_dp_q   : act_dp_q;
    hex_d    = src_word[{sel_d, 2'b00} +: 4];
    dp_d     = src_dp[sel_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bcnt_q      <= '0;
      an_q        <= 4'hF;
      hex_q       <= '0;
      dp_q        <= 1'b0;
      sel_q       <= '0;
      fd_q        <= 1'b0;
      act_word_q  <= '0;
      act_dp_q    <= '0;
      pend_word_q <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
    end else begin
      fd_q <= 1'b0;

      if (xfer) begin
        act_word_q  <= pend_word_q;
        act_dp_q    <= pend_dp_q;
        pend_full_q <= 1'b0;
      end
      // Accept and transfer are exclusive: accept needs pending empty.
      if (ld.load_valid && !pend_full_q) begin
        pend_word_q <= ld.load_data;
        pend_dp_q   <= ld.load_dp;
        pend_full_q <= 1'b1;
      end

      if (enter_show) begin
        state_q <= S_SHOW;
        cnt_q   <= '0;
        sel_q   <= sel_d;
        an_q    <= ~(4'b0001 << sel_d);
        hex_q   <= hex_d;
        dp_q    <= dp_d;
        fd_q    <= boundary;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_SHOW: begin
            if (cnt_q >= period) begin
              state_q <= S_BLANK;
              bcnt_q  <= '0;
              an_q    <= 4'hF;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_BLANK: begin
            if (blank_end) state_q <= S_IDLE;
            else           bcnt_q  <= bcnt_q + 4'd1;
          end
          default: begin
            state_q <= S_IDLE;
            an_q    <= 4'hF;
          end
        endcase
      end
    end
  end

  assign an            = an_q;
  assign hex           = hex_q;
  assign dp            = dp_q;
  assign digit_sel     = sel_q;
  assign frame_done    = fd_q;
  assign ld.load_ready = ~pend_full_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: expected scan positions come from frame arithmetic
// (enabled-digit list, dwell+blank slots) rather than a state machine.
module tb_seg_scan_ctrl;
  localparam int DIV_W = 6;
  localparam int BLANK = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [DIV_W-1:0] period = '0;
  logic [3:0]       digit_en = '0;
  logic [3:0]       an, hex;
  logic             dp, frame_done;
  logic [1:0]       digit_sel;
  int               checks = 0;
  int               errors = 0;

  seg_scan_ctrl_if ld();

  seg_scan_ctrl #(.DIV_W(DIV_W), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .period(period), .digit_en(digit_en), .ld(ld),
    .an(an), .hex(hex), .dp(dp), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Position t clocks after the first SHOW of a steady scan.
  function automatic void model_at(input int t, input logic [3:0] en, input int per,
                                   output int dig, output bit lit, output bit fd);
    int lst[$];
    int s, f, p;
    for (int i = 0; i < 4; i++) if (en[i]) lst.push_back(i);
    s   = per + 1 + BLANK;
    f   = lst.size() * s;
    p   = t % f;
    dig = lst[p / s];
    lit = (p % s) < (per + 1);
    fd  = (p == 0);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    ld.load_valid = 1'b0; ld.load_data = '0; ld.load_dp = '0;
    digit_en = '0; period = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Load a word while idle, then enable scanning; next posedge starts t=0.
  task automatic start_scan(input int per, input logic [3:0] en, input logic [15:0] w,
                            input logic [3:0] dpw);
    ld.load_valid = 1'b1; ld.load_data = w; ld.load_dp = dpw;
    @(negedge clk);
    ld.load_valid = 1'b0;
    @(negedge clk);
    period = DIV_W'(per);
    digit_en = en;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %h exp f", an); end
    checks++; if (hex !== 4'h0) begin errors++; $display("FAIL reset_hex got %h exp 0", hex); end
    checks++; if (dp !== 1'b0) begin errors++; $display("FAIL reset_dp got %b exp 0", dp); end
    checks++; if (digit_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", digit_sel); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done); end
    checks++; if (ld.load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ld.load_ready); end
    do_reset();
  endtask

  task automatic test_scan(input int per, input logic [3:0] en, input logic [15:0] w,
                           input logic [3:0] dpw, input int nframes);
    int dig, nen, flen; bit lit, fd; logic [3:0] ea, eh; logic ed;
    do_reset();
    start_scan(per, en, w, dpw);
    nen = 0;
    for (int i = 0; i < 4; i++) if (en[i]) nen++;
    flen = nen * (per + 1 + BLANK);
    for (int t = 0; t < nframes * flen; t++) begin
      @(negedge clk);
      model_at(t, en, per, dig, lit, fd);
      ea = lit ? ~(4'b0001 << dig) : 4'hF;
      eh = w[dig*4 +: 4];
      ed = dpw[dig];
      checks++; if (an !== ea) begin errors++; $display("FAIL scan_an p=%0d en=%h t=%0d got %h exp %h", per, en, t, an, ea); end
      checks++; if (hex !== eh) begin errors++; $display("FAIL scan_hex p=%0d en=%h t=%0d got %h exp %h", per, en, t, hex, eh); end
      checks++; if (dp !== ed) begin errors++; $display("FAIL scan_dp p=%0d en=%h t=%0d got %b exp %b", per, en, t, dp, ed); end
      checks++; if (digit_sel !== 2'(dig)) begin errors++; $display("FAIL scan_sel p=%0d en=%h t=%0d got %0d exp %0d", per, en, t, digit_sel, dig); end
      checks++; if (frame_done !== fd) begin errors++; $display("FAIL scan_fd p=%0d en=%h t=%0d got %b exp %b", per, en, t, frame_done, fd); end
    end
  endtask

  // Offer a new word during cycle a of a 24-clock frame; a second offer follows while busy.
  task automatic test_load(input int a);
    int dig, sw; bit lit, fd; logic [15:0] w; logic [3:0] dw, ea, eh; logic er;
    do_reset();
    start_scan(3, 4'hF, 16'h1234, 4'h0);
    sw = ((a + 1) / 24 + 1) * 24;
    for (int t = 0; t < 96; t++) begin
      @(negedge clk);
      model_at(t, 4'hF, 3, dig, lit, fd);
      w  = (t >= sw) ? 16'hABCD : 16'h1234;
      dw = (t >= sw) ? 4'b1010 : 4'b0000;
      ea = lit ? ~(4'b0001 << dig) : 4'hF;
      eh = w[dig*4 +: 4];
      er = (t <= a) || (t >= sw);
      checks++; if (an !== ea) begin errors++; $display("FAIL load_an a=%0d t=%0d got %h exp %h", a, t, an, ea); end
      checks++; if (hex !== eh) begin errors++; $display("FAIL load_hex a=%0d t=%0d got %h exp %h", a, t, hex, eh); end
      checks++; if (dp !== dw[dig]) begin errors++; $display("FAIL load_dp a=%0d t=%0d got %b exp %b", a, t, dp, dw[dig]); end
      checks++; if (frame_done !== fd) begin errors++; $display("FAIL load_fd a=%0d t=%0d got %b exp %b", a, t, frame_done, fd); end
      checks++; if (ld.load_ready !== er) begin errors++; $display("FAIL load_ready a=%0d t=%0d got %b exp %b", a, t, ld.load_ready, er); end
      if (t == a) begin
        ld.load_valid = 1'b1; ld.load_data = 16'hABCD; ld.load_dp = 4'b1010;
      end else if (t == a + 1) begin
        ld.load_valid = 1'b1; ld.load_data = 16'h5555; ld.load_dp = 4'hF;
      end else begin
        ld.load_valid = 1'b0;
      end
    end
  endtask

  task automatic test_disable();
    int dig; bit lit, fd; logic [3:0] ea, eh; logic ed;
    do_reset();
    start_scan(3, 4'hF, 16'h1234, 4'b0100);
    for (int t = 0; t < 23; t++) begin
      @(negedge clk);
      if (t < 18) begin
        model_at(t, 4'hF, 3, dig, lit, fd);
        ea = lit ? ~(4'b0001 << dig) : 4'hF;
      end else if (t <= 20) begin
        dig = 2; ea = 4'hF; fd = 1'b0;
      end else begin
        dig = 3; ea = 4'b0111; fd = (t == 21);
      end
      eh = 16'h1234 >> (dig * 4);
      ed = (dig == 2);
      checks++; if (an !== ea) begin errors++; $display("FAIL dis_an t=%0d got %h exp %h", t, an, ea); end
      checks++; if (hex !== eh) begin errors++; $display("FAIL dis_hex t=%0d got %h exp %h", t, hex, eh); end
      checks++; if (dp !== ed) begin errors++; $display("FAIL dis_dp t=%0d got %b exp %b", t, dp, ed); end
      checks++; if (digit_sel !== 2'(dig)) begin errors++; $display("FAIL dis_sel t=%0d got %0d exp %0d", t, digit_sel, dig); end
      checks++; if (frame_done !== fd) begin errors++; $display("FAIL dis_fd t=%0d got %b exp %b", t, frame_done, fd); end
      if (t == 13) digit_en = 4'h0;
      if (t == 20) digit_en = 4'b1000;
    end
  endtask

  task automatic test_reset_midshow();
    int dig; bit lit, fd; logic [3:0] ea;
    do_reset();
    start_scan(3, 4'b0110, 16'h9876, 4'hF);
    repeat (2) @(negedge clk);
    checks++; if (an !== 4'b1101) begin errors++; $display("FAIL rst_pre_an got %h exp d", an); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL rst_an got %h exp f", an); end
    checks++; if (hex !== 4'h0) begin errors++; $display("FAIL rst_hex got %h exp 0", hex); end
    checks++; if (dp !== 1'b0) begin errors++; $display("FAIL rst_dp got %b exp 0", dp); end
    checks++; if (digit_sel !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d exp 0", digit_sel); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd got %b exp 0", frame_done); end
    checks++; if (ld.load_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", ld.load_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    // Buffers were cleared, so the resumed scan shows zeros.
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      model_at(t, 4'b0110, 3, dig, lit, fd);
      ea = lit ? ~(4'b0001 << dig) : 4'hF;
      checks++; if (an !== ea) begin errors++; $display("FAIL rst_resume_an t=%0d got %h exp %h", t, an, ea); end
      checks++; if (hex !== 4'h0) begin errors++; $display("FAIL rst_resume_hex t=%0d got %h exp 0", t, hex); end
      checks++; if (frame_done !== fd) begin errors++; $display("FAIL rst_resume_fd t=%0d got %b exp %b", t, frame_done, fd); end
    end
  endtask

  initial begin
    ld.load_valid = 1'b0; ld.load_data = '0; ld.load_dp = '0;
    test_reset();
    test_scan(3, 4'hF, 16'h1234, 4'h0, 2);
    test_scan(0, 4'b0101, 16'h1234, 4'b0001, 3);
    test_scan(2, 4'b0010, 16'hF00D, 4'b0010, 3);
    for (int r = 0; r < 6; r++)
      test_scan(int'($urandom_range(0, 5)), 4'($urandom_range(1, 15)),
                16'($urandom), 4'($urandom), 2);
    test_load(2);
    test_load(23);
    test_disable();
    test_reset_midshow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
